// File: rtl/edge_acc_param.sv
// edge_acc_param: Sobel edge-magnitude accelerator sharing a single-port word memory with the CPU.
// Reads an IMG_W x IMG_H 8-bit image (four pixels per word), writes the full-size magnitude image.
// Optional build macro EDGE_ACC_THRESH_EN: adds parameter THRESH and binarises interior pixels.
module edge_acc_param #(
    parameter int IMG_W    = 352,
    parameter int IMG_H    = 288,
    parameter int ADDR_W   = 16,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = IMG_W*IMG_H/4
`ifdef EDGE_ACC_THRESH_EN
    ,
    parameter int THRESH   = 128
`endif
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] addr,
    input  logic [31:0]       dataR,
    output logic [31:0]       dataW,
    output logic              en,
    output logic              we,
    input  logic              start,
    output logic              finish
);

    localparam int WPR = IMG_W/4;
    localparam logic [ADDR_W-1:0] C_WPR     = ADDR_W'(WPR);
    localparam logic [ADDR_W-1:0] C_LASTCOL = ADDR_W'(WPR-1);
    localparam logic [ADDR_W-1:0] C_LASTINT = ADDR_W'(IMG_H-2);
    localparam logic [ADDR_W-1:0] C_SRC     = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] C_DST     = ADDR_W'(DST_BASE);
    localparam logic [ADDR_W-1:0] C_BOTOFF  = ADDR_W'((IMG_H-1)*WPR);
    localparam logic [ADDR_W-1:0] C_ONE     = ADDR_W'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_TOP, S_LT, S_LM, S_LB, S_LC,
        S_RDT, S_RDM, S_RDB, S_WR, S_BOT, S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_col;
    logic              r_finish;

    logic [7:0]        r_topPrev, r_midPrev, r_botPrev;
    logic [31:0]       r_topCur,  r_midCur,  r_botCur;
    logic [31:0]       r_topNext, r_midNext;

    logic [ADDR_W-1:0] w_topOff, w_midOff, w_botOff, w_colNext;
    logic              w_lastCol;
    logic [47:0]       w_topWin, w_midWin, w_botWin;
    logic [31:0]       w_outWord;

    // One Sobel output pixel from its 3x3 neighbourhood (centre pixel unused), saturated to 8 bits.
    function automatic logic [7:0] sobelPix(input logic [7:0] t0, input logic [7:0] t1,
                                            input logic [7:0] t2, input logic [7:0] m0,
                                            input logic [7:0] m2, input logic [7:0] b0,
                                            input logic [7:0] b1, input logic [7:0] b2);
        logic [9:0]         sumL, sumR, sumT, sumB;
        logic signed [10:0] gx, gy;
        logic [10:0]        ax, ay;
        logic [11:0]        mag;
        logic [7:0]         sat;
        sumL = {2'b00, t0} + {1'b0, m0, 1'b0} + {2'b00, b0};
        sumR = {2'b00, t2} + {1'b0, m2, 1'b0} + {2'b00, b2};
        sumT = {2'b00, t0} + {1'b0, t1, 1'b0} + {2'b00, t2};
        sumB = {2'b00, b0} + {1'b0, b1, 1'b0} + {2'b00, b2};
        gx   = $signed({1'b0, sumR}) - $signed({1'b0, sumL});
        gy   = $signed({1'b0, sumB}) - $signed({1'b0, sumT});
        ax   = gx[10] ? $unsigned(-gx) : $unsigned(gx);
        ay   = gy[10] ? $unsigned(-gy) : $unsigned(gy);
        mag  = {1'b0, ax} + {1'b0, ay};
        sat  = (mag > 12'd255) ? 8'hFF : mag[7:0];
`ifdef EDGE_ACC_THRESH_EN
        sobelPix = (int'(sat) >= THRESH) ? 8'hFF : 8'h00;
`else
        sobelPix = sat;
`endif
    endfunction

    // Row offsets of the three window rows and the column-boundary flags used by the decodes.
    always_comb begin
        w_topOff  = (r_row - C_ONE) * C_WPR;
        w_midOff  = w_topOff + C_WPR;
        w_botOff  = w_midOff + C_WPR;
        w_colNext = r_col + C_ONE;
        w_lastCol = (r_col == C_LASTCOL);
    end

    // Build the output word; the bottom row's right neighbour comes straight off the read bus.
    always_comb begin
        w_topWin  = {r_topNext[7:0], r_topCur, r_topPrev};
        w_midWin  = {r_midNext[7:0], r_midCur, r_midPrev};
        w_botWin  = {dataR[7:0],     r_botCur, r_botPrev};
        w_outWord = '0;
        for (int k = 0; k < 4; k++) begin
            if (!((k == 0) && (r_col == '0)) && !((k == 3) && w_lastCol)) begin
                w_outWord[8*k +: 8] = sobelPix(w_topWin[8*k +: 8], w_topWin[8*(k+1) +: 8],
                                               w_topWin[8*(k+2) +: 8], w_midWin[8*k +: 8],
                                               w_midWin[8*(k+2) +: 8], w_botWin[8*k +: 8],
                                               w_botWin[8*(k+1) +: 8], w_botWin[8*(k+2) +: 8]);
            end
        end
    end

    // Bus decode: at most one transaction per cycle; last-column read slots stay off the bus.
    always_comb begin
        en    = 1'b0;
        we    = 1'b0;
        addr  = '0;
        dataW = '0;
        case (r_state)
            S_TOP: begin
                en   = 1'b1;
                we   = 1'b1;
                addr = C_DST + r_col;
            end
            S_LT: begin
                en   = 1'b1;
                addr = C_SRC + w_topOff;
            end
            S_LM: begin
                en   = 1'b1;
                addr = C_SRC + w_midOff;
            end
            S_LB: begin
                en   = 1'b1;
                addr = C_SRC + w_botOff;
            end
            S_RDT: if (!w_lastCol) begin
                en   = 1'b1;
                addr = C_SRC + w_topOff + w_colNext;
            end
            S_RDM: if (!w_lastCol) begin
                en   = 1'b1;
                addr = C_SRC + w_midOff + w_colNext;
            end
            S_RDB: if (!w_lastCol) begin
                en   = 1'b1;
                addr = C_SRC + w_botOff + w_colNext;
            end
            S_WR: begin
                en    = 1'b1;
                we    = 1'b1;
                addr  = C_DST + w_midOff + r_col;
                dataW = w_outWord;
            end
            S_BOT: begin
                en   = 1'b1;
                we   = 1'b1;
                addr = C_DST + C_BOTOFF + r_col;
            end
            default: ;
        endcase
    end

    // Sequencer: border rows, per-row window load, per-column read/read/read/write, handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_finish  <= 1'b0;
            r_topPrev <= '0;
            r_midPrev <= '0;
            r_botPrev <= '0;
            r_topCur  <= '0;
            r_midCur  <= '0;
            r_botCur  <= '0;
            r_topNext <= '0;
            r_midNext <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_state <= S_TOP;
                    r_col   <= '0;
                end
                S_TOP: begin
                    if (w_lastCol) begin
                        r_col   <= '0;
                        r_row   <= C_ONE;
                        r_state <= S_LT;
                    end else begin
                        r_col <= w_colNext;
                    end
                end
                S_LT: r_state <= S_LM;
                S_LM: begin
                    r_topCur <= dataR;
                    r_state  <= S_LB;
                end
                S_LB: begin
                    r_midCur <= dataR;
                    r_state  <= S_LC;
                end
                S_LC: begin
                    r_botCur <= dataR;
                    r_state  <= S_RDT;
                end
                S_RDT: r_state <= S_RDM;
                S_RDM: begin
                    r_topNext <= dataR;
                    r_state   <= S_RDB;
                end
                S_RDB: begin
                    r_midNext <= dataR;
                    r_state   <= S_WR;
                end
                S_WR: begin
                    r_topPrev <= r_topCur[31:24];
                    r_midPrev <= r_midCur[31:24];
                    r_botPrev <= r_botCur[31:24];
                    r_topCur  <= r_topNext;
                    r_midCur  <= r_midNext;
                    r_botCur  <= dataR;
                    if (w_lastCol) begin
                        r_col <= '0;
                        if (r_row == C_LASTINT) begin
                            r_state <= S_BOT;
                        end else begin
                            r_row   <= r_row + C_ONE;
                            r_state <= S_LT;
                        end
                    end else begin
                        r_col   <= w_colNext;
                        r_state <= S_RDT;
                    end
                end
                S_BOT: begin
                    if (w_lastCol) begin
                        r_col    <= '0;
                        r_finish <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_col <= w_colNext;
                    end
                end
                S_DONE: if (!start) begin
                    r_finish <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign finish = r_finish;

endmodule
